ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Shares the split even/odd on-chip RAM between two requesters: port 0 (CPU core) and port 1 (debug/loader).
- Converts byte-addressed 8-bit or 16-bit little-endian accesses into even/odd bank addresses, write strobes and byte lanes.
- Sequences the one-cycle registered read return and flags accesses outside the RAM window.
- Sits directly between the requesters and the ram module.

Parameters:
- ADDRBITS, 10, RAM size is 1<<ADDRBITS bytes; window is [0x4000-SIZE, 0x3fff]; valid range 10..13.
- MAXWAIT, 4, max consecutive cycles port 1 may be refused before it is forced to win; range 1..15.

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req0, req1  in  1  access request, held until granted
- we0, we1  in  1  1 = write, 0 = read
- wide0, wide1  in  1  1 = 16-bit access, 0 = 8-bit
- addr0, addr1  in  16  byte address
- wdata0, wdata1  in  16  write data; low byte goes to addr, high byte to addr+1
- gnt0, gnt1  out  1  combinational grant; the access occurs in the cycle where req && gnt
- rvalid0, rvalid1  out  1  read data valid, registered
- rdata0, rdata1  out  16  read data; 8-bit reads zero-extend
- err0, err1  out  1  out-of-window flag, valid with rvalid (reads) or the cycle after grant (writes)
- read_addr_even, read_addr_odd, write_addr_even, write_addr_odd  out  15  bank word addresses (byte address >> 1)
- write_data_even, write_data_odd  out  8  bank write bytes
- write_en_even, write_en_odd  out  1  bank write strobes
- read_data_even, read_data_odd  in  8  bank read data, one cycle after address

Behaviour:
- Reset:
  - While reset is high, gnt0/1 = 0, write_en_* = 0.
  - Registered outputs clear to 0 (rvalid*, rdata*, err*).
  - Wait counter clears to 0; any in-flight read return is discarded.
- Arbitration (at most one grant per cycle):
  - Port 0 wins by default.
  - Port 1 wins if req1 && (!req0 || waitcnt == MAXWAIT).
  - waitcnt increments (saturating at MAXWAIT) each cycle req1 is high and not granted. It clears when port 1 is granted or req1 is low.
  - With MAXWAIT=4 and both requesting continuously, the pattern is p0 x4, p1, p0 x4, p1, ...
- Lane mapping, for byte address A and word address W = A[15:1]:
  - A even: byte A uses the even bank at W; byte A+1 uses the odd bank at W.
  - A odd: byte A uses the odd bank at W; byte A+1 uses the even bank at W+1.
  - 8-bit access: only the lane holding byte A is written; the read selects that lane.
- Window and errors:
  - If byte A is outside the window: no bank write, rdata = 0x0000, err = 1.
  - Wide access with A = 0x3fff (A+1 outside the window): the low byte proceeds normally, the high-byte write is suppressed, rdata[15:8] = 0x00, err = 1.
- Read latency:
  - Read granted in cycle N produces rvalid = 1 for exactly one cycle at N+1 on the granted port, with rdata and err.
  - The alignment, width, owner and err of the read are captured into one pipeline register stage at N.
  - Back-to-back reads are accepted every cycle.
- Write timing:
  - write_en_* is asserted combinationally in the granted cycle.
  - A read granted at N+1 of an address written at N returns the new data.
  - Writes produce no rvalid. errX for a write pulses at N+1.
- Idle bank address outputs carry the port 0 address; values are don't-care when there is no grant.
- Reset asserted in the cycle a read was granted: no rvalid appears at N+1.

Decomposition:
- Package f8_ram_pkg:
  - ram_base(ADDRBITS) constant function.
  - in_window(addr, ADDRBITS) function.
  - typedef ram_req_t {we, wide, addr[15:0], wdata[15:0]}.
  - typedef rd_ctx_t {owner, odd, wide, err_lo, err_hi}.
- Sub-module ram_lane_mapper: purely combinational. Maps one ram_req_t into bank addresses, write bytes and strobes; reassembles 16-bit read data from the bank bytes plus rd_ctx_t.

Test Plan (ADDRBITS=10, window 0x3c00-0x3fff):
1. Port 0 wide write at 0x3c01 with 0xBEEF, then wide read at 0x3c01 → odd bank word 0x1e00 = 0xEF, even bank word 0x1e01 = 0xBE; rvalid0 one cycle after grant, rdata0 = 0xBEEF, err0 = 0.
2. Byte write 0x3c04 = 0x5A, then 8-bit read → only write_en_even pulses; rdata = 0x005A.
3. req0 and req1 held high for 12 cycles, MAXWAIT=4 → gnt1 in cycles 4 and 9 only; all other cycles gnt0.
4. Wide write at 0x3fff with 0x1234 → odd bank word 0x1fff = 0x34, no even write; err = 1; a following wide read returns 0x0034 with err = 1.
5. Read at 0x2000 (out of window) → no write strobes, rvalid with rdata = 0x0000, err = 1.
6. Reset pulsed in the cycle a read is granted → no rvalid the next cycle; gnt low during reset; waitcnt = 0 afterwards (port 0 wins first after reset).

Source files
------------

// File: rtl/f8_ram_pkg.sv
// Shared types and window helpers for the split even/odd RAM arbiter.
package f8_ram_pkg;

  typedef struct packed {
    logic        we;
    logic        wide;
    logic [15:0] addr;
    logic [15:0] wdata;
  } ram_req_t;

  typedef struct packed {
    logic owner;
    logic odd;
    logic wide;
    logic err_lo;
    logic err_hi;
  } rd_ctx_t;

  // RAM occupies the top of the 16 KiB space: [0x4000 - size, 0x3fff].
  function automatic logic [15:0] ram_base(input int unsigned addrbits);
    return 16'h4000 - 16'(1 << addrbits);
  endfunction

  function automatic logic in_window(input logic [15:0] addr, input int unsigned addrbits);
    return (addr >= ram_base(addrbits)) && (addr <= 16'h3fff);
  endfunction

endpackage

// File: rtl/ram_lane_mapper.sv
// Combinational byte-lane mapping between a byte-addressed request and the even/odd banks.
module ram_lane_mapper
  import f8_ram_pkg::*;
#(
  parameter int unsigned ADDRBITS = 10
) (
  input  ram_req_t    i_req,
  input  logic        i_grant,
  input  logic        i_owner,
  input  rd_ctx_t     i_rd_ctx,
  input  logic [7:0]  i_rd_even,
  input  logic [7:0]  i_rd_odd,
  output logic [14:0] o_addr_even,
  output logic [14:0] o_addr_odd,
  output logic [7:0]  o_wdata_even,
  output logic [7:0]  o_wdata_odd,
  output logic        o_we_even,
  output logic        o_we_odd,
  output rd_ctx_t     o_ctx,
  output logic [15:0] o_rdata,
  output logic        o_rd_err
);

  logic [14:0] w_word;
  logic [15:0] w_addr_hi;
  logic        w_odd;
  logic        w_err_lo;
  logic        w_err_hi;
  logic        w_lo_en;
  logic        w_hi_en;
  logic [7:0]  w_lo_byte;
  logic [7:0]  w_hi_byte;

  assign w_word    = i_req.addr[15:1];
  assign w_odd     = i_req.addr[0];
  assign w_addr_hi = i_req.addr + 16'd1;
  assign w_err_lo  = !in_window(i_req.addr, ADDRBITS);
  assign w_err_hi  = i_req.wide && !in_window(w_addr_hi, ADDRBITS);

  // Odd start: low byte sits in the odd bank, high byte spills into the next even word.
  assign o_addr_odd   = w_word;
  assign o_addr_even  = w_odd ? w_word + 15'd1 : w_word;
  assign o_wdata_even = w_odd ? i_req.wdata[15:8] : i_req.wdata[7:0];
  assign o_wdata_odd  = w_odd ? i_req.wdata[7:0]  : i_req.wdata[15:8];

  assign w_lo_en   = i_grant && i_req.we && !w_err_lo;
  assign w_hi_en   = w_lo_en && i_req.wide && !w_err_hi;
  assign o_we_even = w_odd ? w_hi_en : w_lo_en;
  assign o_we_odd  = w_odd ? w_lo_en : w_hi_en;

  assign o_ctx = '{owner: i_owner, odd: w_odd, wide: i_req.wide,
                   err_lo: w_err_lo, err_hi: w_err_hi};

  assign w_lo_byte = i_rd_ctx.odd ? i_rd_odd  : i_rd_even;
  assign w_hi_byte = i_rd_ctx.odd ? i_rd_even : i_rd_odd;

  always_comb begin
    o_rdata = '0;
    if (!i_rd_ctx.err_lo) begin
      o_rdata[7:0] = w_lo_byte;
      if (i_rd_ctx.wide && !i_rd_ctx.err_hi) o_rdata[15:8] = w_hi_byte;
    end
  end

  assign o_rd_err = i_rd_ctx.err_lo | i_rd_ctx.err_hi;

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of the split even/odd RAM with starvation-bounded priority for port 1.
module ram_arbiter
  import f8_ram_pkg::*;
#(
  parameter int unsigned ADDRBITS = 10,
  parameter int unsigned MAXWAIT  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic        wide0,
  input  logic        wide1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic [14:0] read_addr_even,
  output logic [14:0] read_addr_odd,
  output logic [14:0] write_addr_even,
  output logic [14:0] write_addr_odd,
  output logic [7:0]  write_data_even,
  output logic [7:0]  write_data_odd,
  output logic        write_en_even,
  output logic        write_en_odd,
  input  logic [7:0]  read_data_even,
  input  logic [7:0]  read_data_odd
);

  logic [3:0]  r_waitcnt;
  logic        r_rd_vld;
  rd_ctx_t     r_rd_ctx;
  logic        r_werr0;
  logic        r_werr1;

  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_any;
  ram_req_t    w_sel;
  rd_ctx_t     w_ctx;
  logic [14:0] w_addr_even;
  logic [14:0] w_addr_odd;
  logic [15:0] w_rdata;
  logic        w_rd_err;
  logic        w_req_err;

  assign w_gnt1 = !reset && req1 && (!req0 || (r_waitcnt == 4'(MAXWAIT)));
  assign w_gnt0 = !reset && req0 && !w_gnt1;
  assign w_any  = w_gnt0 | w_gnt1;
  assign gnt0   = w_gnt0;
  assign gnt1   = w_gnt1;

  // Port 0 drives the bank address bus whenever port 1 is not granted.
  assign w_sel = w_gnt1 ? '{we: we1, wide: wide1, addr: addr1, wdata: wdata1}
                        : '{we: we0, wide: wide0, addr: addr0, wdata: wdata0};

  ram_lane_mapper #(.ADDRBITS(ADDRBITS)) u_mapper (
    .i_req        (w_sel),
    .i_grant      (w_any),
    .i_owner      (w_gnt1),
    .i_rd_ctx     (r_rd_ctx),
    .i_rd_even    (read_data_even),
    .i_rd_odd     (read_data_odd),
    .o_addr_even  (w_addr_even),
    .o_addr_odd   (w_addr_odd),
    .o_wdata_even (write_data_even),
    .o_wdata_odd  (write_data_odd),
    .o_we_even    (write_en_even),
    .o_we_odd     (write_en_odd),
    .o_ctx        (w_ctx),
    .o_rdata      (w_rdata),
    .o_rd_err     (w_rd_err)
  );

  assign read_addr_even  = w_addr_even;
  assign read_addr_odd   = w_addr_odd;
  assign write_addr_even = w_addr_even;
  assign write_addr_odd  = w_addr_odd;
  assign w_req_err       = w_ctx.err_lo | w_ctx.err_hi;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_waitcnt <= '0;
      r_rd_vld  <= 1'b0;
      r_rd_ctx  <= '0;
      r_werr0   <= 1'b0;
      r_werr1   <= 1'b0;
    end else begin
      if (req1 && !w_gnt1) begin
        if (r_waitcnt != 4'(MAXWAIT)) r_waitcnt <= r_waitcnt + 4'd1;
      end else begin
        r_waitcnt <= '0;
      end
      r_rd_vld <= w_any && !w_sel.we;
      if (w_any && !w_sel.we) r_rd_ctx <= w_ctx;
      r_werr0 <= w_gnt0 && w_sel.we && w_req_err;
      r_werr1 <= w_gnt1 && w_sel.we && w_req_err;
    end
  end

  assign rvalid0 = r_rd_vld && !r_rd_ctx.owner;
  assign rvalid1 = r_rd_vld &&  r_rd_ctx.owner;
  assign rdata0  = rvalid0 ? w_rdata : '0;
  assign rdata1  = rvalid1 ? w_rdata : '0;
  assign err0    = (rvalid0 && w_rd_err) | r_werr0;
  assign err1    = (rvalid1 && w_rd_err) | r_werr1;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural even/odd bank RAM.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, we0, we1, wide0, wide1;
  logic [15:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [15:0] rdata0, rdata1;
  logic [14:0] read_addr_even, read_addr_odd, write_addr_even, write_addr_odd;
  logic [7:0]  write_data_even, write_data_odd;
  logic        write_en_even, write_en_odd;
  logic [7:0]  read_data_even, read_data_odd;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem_e [0:32767];
  logic [7:0] mem_o [0:32767];

  always #5 clk = ~clk;

  ram_arbiter #(.ADDRBITS(10), .MAXWAIT(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .wide0(wide0), .wide1(wide1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .read_addr_even(read_addr_even), .read_addr_odd(read_addr_odd),
    .write_addr_even(write_addr_even), .write_addr_odd(write_addr_odd),
    .write_data_even(write_data_even), .write_data_odd(write_data_odd),
    .write_en_even(write_en_even), .write_en_odd(write_en_odd),
    .read_data_even(read_data_even), .read_data_odd(read_data_odd)
  );

  always @(posedge clk) begin
    if (write_en_even) mem_e[write_addr_even] <= write_data_even;
    if (write_en_odd)  mem_o[write_addr_odd]  <= write_data_odd;
    read_data_even <= mem_e[read_addr_even];
    read_data_odd  <= mem_o[read_addr_odd];
  end

  task automatic set0(input logic we, input logic wide, input logic [15:0] a, input logic [15:0] d);
    req0 = 1'b1; we0 = we; wide0 = wide; addr0 = a; wdata0 = d;
  endtask

  task automatic set1(input logic we, input logic wide, input logic [15:0] a, input logic [15:0] d);
    req1 = 1'b1; we1 = we; wide1 = wide; addr1 = a; wdata1 = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set0(1'b1, 1'b1, 16'h3c00, 16'hdead);
    repeat (2) @(negedge clk);
    #1;
    tests++; if (gnt0 !== 1'b0) begin fails++; $display("FAIL reset_gnt0: got %b want 0", gnt0); end
    tests++; if ({write_en_even, write_en_odd} !== 2'b00) begin fails++; $display("FAIL reset_we: got %b want 00", {write_en_even, write_en_odd}); end
    tests++; if ({rvalid0, rvalid1, err0, err1} !== 4'b0000) begin fails++; $display("FAIL reset_flags: got %b want 0000", {rvalid0, rvalid1, err0, err1}); end
    tests++; if ({rdata0, rdata1} !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0", {rdata0, rdata1}); end
    @(negedge clk);
    reset = 1'b0; req0 = 1'b0;
  endtask

  task automatic test_write_read_wide();
    @(negedge clk);
    set0(1'b1, 1'b1, 16'h3c01, 16'hBEEF);
    #1;
    tests++; if (gnt0 !== 1'b1) begin fails++; $display("FAIL t1_gnt: got %b want 1", gnt0); end
    tests++; if ({write_en_odd, write_en_even} !== 2'b11) begin fails++; $display("FAIL t1_we: got %b want 11", {write_en_odd, write_en_even}); end
    tests++; if ({write_addr_odd, write_addr_even} !== {15'h1e00, 15'h1e01}) begin fails++; $display("FAIL t1_waddr: got %h/%h want 1e00/1e01", write_addr_odd, write_addr_even); end
    tests++; if ({write_data_odd, write_data_even} !== 16'hEFBE) begin fails++; $display("FAIL t1_wdata: got %h/%h want ef/be", write_data_odd, write_data_even); end
    @(negedge clk);
    set0(1'b0, 1'b1, 16'h3c01, 16'h0000);
    #1;
    tests++; if ({rvalid0, err0} !== 2'b00) begin fails++; $display("FAIL t1_wr_norv: got %b want 00", {rvalid0, err0}); end
    @(negedge clk);
    req0 = 1'b0;
    #1;
    tests++; if (rvalid0 !== 1'b1) begin fails++; $display("FAIL t1_rvalid: got %b want 1", rvalid0); end
    tests++; if (rdata0 !== 16'hBEEF) begin fails++; $display("FAIL t1_rdata: got %h want beef", rdata0); end
    tests++; if (err0 !== 1'b0) begin fails++; $display("FAIL t1_err: got %b want 0", err0); end
    @(negedge clk);
    #1;
    tests++; if (rvalid0 !== 1'b0) begin fails++; $display("FAIL t1_rvalid_once: got %b want 0", rvalid0); end
  endtask

  task automatic test_byte_access();
    @(negedge clk);
    set0(1'b1, 1'b1, 16'h3c04, 16'hFFFF);
    @(negedge clk);
    set0(1'b1, 1'b0, 16'h3c04, 16'hA55A);
    #1;
    tests++; if ({write_en_even, write_en_odd} !== 2'b10) begin fails++; $display("FAIL t2_we: got %b want 10", {write_en_even, write_en_odd}); end
    tests++; if (write_data_even !== 8'h5A) begin fails++; $display("FAIL t2_wdata: got %h want 5a", write_data_even); end
    @(negedge clk);
    set0(1'b0, 1'b0, 16'h3c04, 16'h0000);
    @(negedge clk);
    set0(1'b0, 1'b1, 16'h3c04, 16'h0000);
    #1;
    tests++; if (rdata0 !== 16'h005A) begin fails++; $display("FAIL t2_rdata8: got %h want 005a", rdata0); end
    @(negedge clk);
    req0 = 1'b0;
    #1;
    tests++; if (rdata0 !== 16'hFF5A) begin fails++; $display("FAIL t2_rdata16: got %h want ff5a", rdata0); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    set0(1'b0, 1'b1, 16'h3c01, 16'h0000);
    @(negedge clk);
    set0(1'b0, 1'b0, 16'h3c04, 16'h0000);
    #1;
    tests++; if ({rvalid0, rdata0} !== {1'b1, 16'hBEEF}) begin fails++; $display("FAIL b2b_first: got %b/%h want 1/beef", rvalid0, rdata0); end
    @(negedge clk);
    req0 = 1'b0;
    #1;
    tests++; if ({rvalid0, rdata0} !== {1'b1, 16'h005A}) begin fails++; $display("FAIL b2b_second: got %b/%h want 1/005a", rvalid0, rdata0); end
  endtask

  task automatic test_arbitration();
    @(negedge clk);
    set0(1'b0, 1'b1, 16'h3c02, 16'h0000);
    set1(1'b0, 1'b1, 16'h3c10, 16'h0000);
    for (int c = 0; c < 12; c++) begin
      #1;
      tests++;
      if ({gnt0, gnt1} !== ((c == 4 || c == 9) ? 2'b01 : 2'b10)) begin
        fails++; $display("FAIL arb_cycle%0d: got gnt0/gnt1=%b want %b", c, {gnt0, gnt1}, (c == 4 || c == 9) ? 2'b01 : 2'b10);
      end
      tests++;
      if (rvalid1 !== ((c == 5 || c == 10) ? 1'b1 : 1'b0)) begin
        fails++; $display("FAIL arb_rvalid1_cycle%0d: got %b", c, rvalid1);
      end
      @(negedge clk);
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  task automatic test_wide_edge();
    @(negedge clk);
    set0(1'b1, 1'b1, 16'h3fff, 16'h1234);
    #1;
    tests++; if ({write_en_odd, write_en_even} !== 2'b10) begin fails++; $display("FAIL t4_we: got %b want 10", {write_en_odd, write_en_even}); end
    tests++; if ({write_addr_odd, write_data_odd} !== {15'h1fff, 8'h34}) begin fails++; $display("FAIL t4_wodd: got %h/%h want 1fff/34", write_addr_odd, write_data_odd); end
    @(negedge clk);
    set0(1'b0, 1'b1, 16'h3fff, 16'h0000);
    #1;
    tests++; if ({err0, rvalid0} !== 2'b10) begin fails++; $display("FAIL t4_wr_err: got err/rvalid=%b want 10", {err0, rvalid0}); end
    @(negedge clk);
    req0 = 1'b0;
    #1;
    tests++; if ({rvalid0, rdata0, err0} !== {1'b1, 16'h0034, 1'b1}) begin fails++; $display("FAIL t4_rd: got %b/%h/%b want 1/0034/1", rvalid0, rdata0, err0); end
    @(negedge clk);
    #1;
    tests++; if (err0 !== 1'b0) begin fails++; $display("FAIL t4_err_clear: got %b want 0", err0); end
  endtask

  task automatic test_out_of_window();
    @(negedge clk);
    set1(1'b1, 1'b1, 16'h2000, 16'h7777);
    #1;
    tests++; if ({gnt1, write_en_even, write_en_odd} !== 3'b100) begin fails++; $display("FAIL t5_wr: got gnt1/we=%b want 100", {gnt1, write_en_even, write_en_odd}); end
    @(negedge clk);
    set1(1'b0, 1'b1, 16'h2000, 16'h0000);
    #1;
    tests++; if ({err1, rvalid1, err0} !== 3'b100) begin fails++; $display("FAIL t5_wr_err: got %b want 100", {err1, rvalid1, err0}); end
    @(negedge clk);
    req1 = 1'b0;
    #1;
    tests++; if ({rvalid1, rdata1, err1, rvalid0} !== {1'b1, 16'h0000, 1'b1, 1'b0}) begin fails++; $display("FAIL t5_rd: got %b/%h/%b/%b want 1/0000/1/0", rvalid1, rdata1, err1, rvalid0); end
  endtask

  task automatic test_idle_addr();
    @(negedge clk);
    req0 = 1'b0; req1 = 1'b0; addr0 = 16'h3c03; addr1 = 16'h3c40;
    #1;
    tests++; if ({read_addr_even, read_addr_odd} !== {15'h1e02, 15'h1e01}) begin fails++; $display("FAIL idle_addr: got %h/%h want 1e02/1e01", read_addr_even, read_addr_odd); end
  endtask

  task automatic test_reset_midstream();
    @(negedge clk);
    set0(1'b0, 1'b1, 16'h3c01, 16'h0000);
    set1(1'b0, 1'b1, 16'h3c10, 16'h0000);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    tests++; if ({gnt0, gnt1} !== 2'b00) begin fails++; $display("FAIL rst_gnt: got %b want 00", {gnt0, gnt1}); end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (c == 0) begin
        tests++; if (rvalid0 !== 1'b0) begin fails++; $display("FAIL rst_no_rvalid: got %b want 0", rvalid0); end
      end
      tests++;
      if ({gnt0, gnt1} !== ((c == 4) ? 2'b01 : 2'b10)) begin
        fails++; $display("FAIL rst_arb_cycle%0d: got %b want %b", c, {gnt0, gnt1}, (c == 4) ? 2'b01 : 2'b10);
      end
      @(negedge clk);
    end
    req0 = 1'b0; req1 = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      mem_e[i] = 8'h00;
      mem_o[i] = 8'h00;
    end
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    wide0 = 1'b0; wide1 = 1'b0;
    addr0 = 16'h0000; addr1 = 16'h0000; wdata0 = 16'h0000; wdata1 = 16'h0000;
    test_reset();
    test_write_read_wide();
    test_byte_access();
    test_back_to_back();
    test_arbitration();
    test_wide_edge();
    test_out_of_window();
    test_idle_addr();
    test_reset_midstream();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
